// File: rtl/mmm_sched_if.sv
// Bus between the MMM sequencer and its datapath (input_mems, mac_pipe, fifo_out).
// Optional macro MMM_SCHED_PERF_EN adds the stall_cycles counter output.
interface mmm_sched_if #(
    parameter int M    = 7,
    parameter int N    = 9,
    parameter int MAXK = 8
);
    localparam int K_BITS = $clog2(MAXK + 1);
    localparam int CAP_W  = $clog2(N + 1);
    localparam int A_W    = $clog2(M * MAXK);
    localparam int B_W    = $clog2(MAXK * N);

    logic              matrices_loaded;
    logic [K_BITS-1:0] K;
    logic [CAP_W-1:0]  fifo_capacity;
    logic              compute_finished;
    logic [A_W-1:0]    A_read_addr;
    logic [B_W-1:0]    B_read_addr;
    logic              valid_input;
    logic              clear_acc;
    logic              fifo_wr_en;
    logic              busy;
`ifdef MMM_SCHED_PERF_EN
    logic [15:0]       stall_cycles;
`endif

    modport master (
        input  matrices_loaded, K, fifo_capacity,
        output compute_finished, A_read_addr, B_read_addr,
        output valid_input, clear_acc, fifo_wr_en, busy
`ifdef MMM_SCHED_PERF_EN
        , output stall_cycles
`endif
    );

    modport slave (
        output matrices_loaded, K, fifo_capacity,
        input  compute_finished, A_read_addr, B_read_addr,
        input  valid_input, clear_acc, fifo_wr_en, busy
`ifdef MMM_SCHED_PERF_EN
        , input stall_cycles
`endif
    );
endinterface

// File: rtl/mmm_sched.sv
// Credit-aware row-major sequencer for C = A*B; reserves a fifo_out slot per dot product.
// Optional macro MMM_SCHED_PERF_EN adds a saturating HOLD-cycle counter (stall_cycles).
module mmm_sched #(
    parameter int M       = 7,
    parameter int N       = 9,
    parameter int MAXK    = 8,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    mmm_sched_if.master bus
);
    localparam int K_BITS = $clog2(MAXK + 1);
    localparam int CAP_W  = $clog2(N + 1);
    localparam int A_W    = $clog2(M * MAXK);
    localparam int B_W    = $clog2(MAXK * N);
    localparam int R_W    = (M > 1) ? $clog2(M) : 1;
    localparam int C_W    = (N > 1) ? $clog2(N) : 1;
    localparam int WR_LAT = RD_LAT + MAC_LAT;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_HOLD, S_DRAIN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [R_W-1:0]    r_q, r_d;
    logic [C_W-1:0]    c_q, c_d;
    logic [K_BITS-1:0] i_q, i_d;
    logic [K_BITS-1:0] k_q, k_d;
    logic [CAP_W-1:0]  inflight_q, inflight_d;
    logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
    logic [RD_LAT-1:0] clr_sr_q, clr_sr_d;
    logic [WR_LAT-1:0] last_sr_q, last_sr_d;
    logic              fin_q, fin_d;

    logic              issue, reserve, last_term, credit_ok, wr_en;
    logic [31:0]       a_full, b_full;

    assign wr_en     = last_sr_q[WR_LAT-1];
    assign credit_ok = bus.fifo_capacity > inflight_q;
    assign last_term = (i_q == k_q - K_BITS'(1));

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        i_d     = i_q;
        k_d     = k_q;
        issue   = 1'b0;
        reserve = 1'b0;
        case (state_q)
            S_IDLE: begin
                r_d = '0;
                c_d = '0;
                i_d = '0;
                if (bus.matrices_loaded) begin
                    k_d     = (bus.K > K_BITS'(MAXK)) ? K_BITS'(MAXK) : bus.K;
                    state_d = (bus.K == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN, S_HOLD: begin
                // A product only starts when a fifo slot can be reserved; mid-product terms never wait.
                if (i_q != '0 || credit_ok) begin
                    issue   = 1'b1;
                    reserve = (i_q == '0);
                    state_d = S_RUN;
                    if (last_term) begin
                        i_d = '0;
                        if (c_q == C_W'(N - 1)) begin
                            c_d = '0;
                            if (r_q == R_W'(M - 1)) state_d = S_DRAIN;
                            else                    r_d = r_q + R_W'(1);
                        end else begin
                            c_d = c_q + C_W'(1);
                        end
                    end else begin
                        i_d = i_q + K_BITS'(1);
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_DRAIN: if (inflight_q == '0) state_d = S_DONE;
            S_DONE:  if (!bus.matrices_loaded) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q + CAP_W'(reserve) - CAP_W'(wr_en);
        vld_sr_d   = (vld_sr_q << 1) | RD_LAT'(issue);
        clr_sr_d   = (clr_sr_q << 1) | RD_LAT'(reserve);
        last_sr_d  = (last_sr_q << 1) | WR_LAT'(issue && last_term);
        fin_d      = (state_d == S_DONE) && (state_q != S_DONE);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    // NOTE: the strobe delay lines are reset too, so an abandoned job cannot leak a late fifo write after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            i_q        <= '0;
            k_q        <= '0;
            inflight_q <= '0;
            vld_sr_q   <= '0;
            clr_sr_q   <= '0;
            last_sr_q  <= '0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            i_q        <= i_d;
            k_q        <= k_d;
            inflight_q <= inflight_d;
            vld_sr_q   <= vld_sr_d;
            clr_sr_q   <= clr_sr_d;
            last_sr_q  <= last_sr_d;
            fin_q      <= fin_d;
        end
    end

    // Full-width products, truncated to the port widths (bounded by M*MAXK and MAXK*N).
    always_comb begin
        a_full = 32'(r_q) * 32'(k_q) + 32'(i_q);
        b_full = 32'(i_q) * 32'(N) + 32'(c_q);
    end

    assign bus.A_read_addr      = A_W'(a_full);
    assign bus.B_read_addr      = B_W'(b_full);
    assign bus.valid_input      = vld_sr_q[RD_LAT-1];
    assign bus.clear_acc        = clr_sr_q[RD_LAT-1];
    assign bus.fifo_wr_en       = wr_en;
    assign bus.compute_finished = fin_q;
    assign bus.busy             = (state_q != S_IDLE);

`ifdef MMM_SCHED_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && state_d == S_RUN)         stall_d = '0;
        else if (state_q == S_HOLD && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_q <= '0;
        else          stall_q <= stall_d;
    end

    assign bus.stall_cycles = stall_q;
`endif
endmodule
